// File: rtl/fracmod_check_mul.sv
// rtl/fracmod_check_mul.sv - sequential (a*b) mod modu, MSB-first shift-add, one bit of b per cycle
// Optional compare-against-expected output under FRACMOD_CHECK_VERIFY_EN.
module fracmod_check_mul #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] modu,
`ifdef FRACMOD_CHECK_VERIFY_EN
   input  logic [W-1:0] exp,
   output logic         match,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] res,
   output logic         err
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t        state, state_n;
   logic [W-1:0]  a_r, a_n, b_r, b_n, m_r, m_n;
   logic [W-1:0]  acc, acc_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [W-1:0]  res_n;
   logic          err_n, ov_n;
   logic          bad, bad_n;
   logic [W:0]    dbl, dred, sum, sred, m_ext;
`ifdef FRACMOD_CHECK_VERIFY_EN
   logic [W-1:0]  exp_r, exp_n;
   logic          match_n;
`endif

   assign in_ready = (state == IDLE);

   // One doubling and one conditional add per cycle, each folded back below modu.
   always_comb begin
      m_ext = {1'b0, m_r};
      dbl   = {acc, 1'b0};
      dred  = (dbl >= m_ext) ? dbl - m_ext : dbl;
      sum   = dred + (b_r[cnt] ? {1'b0, a_r} : {(W+1){1'b0}});
      sred  = (sum >= m_ext) ? sum - m_ext : sum;
   end

   always_comb begin
      state_n = state;
      a_n     = a_r;
      b_n     = b_r;
      m_n     = m_r;
      acc_n   = acc;
      cnt_n   = cnt;
      res_n   = res;
      err_n   = err;
      ov_n    = out_valid;
      bad_n   = bad;
`ifdef FRACMOD_CHECK_VERIFY_EN
      exp_n   = exp_r;
      match_n = match;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               a_n     = a;
               b_n     = b;
               m_n     = modu;
               acc_n   = '0;
               cnt_n   = CW'(W - 1);
               bad_n   = (a >= modu) || (b >= modu) || (modu < W'(2));
`ifdef FRACMOD_CHECK_VERIFY_EN
               exp_n   = exp;
`endif
               state_n = MUL;
            end
         end
         MUL: begin
            // Operand error is latched at accept and reported on the first MUL edge,
            // so an error result becomes visible one cycle after accept.
            if (bad) begin
               res_n   = '0;
               err_n   = 1'b1;
               ov_n    = 1'b1;
`ifdef FRACMOD_CHECK_VERIFY_EN
               match_n = 1'b0;
`endif
               state_n = DONE;
            end else begin
               acc_n = sred[W-1:0];
               cnt_n = cnt - 1'b1;
               if (cnt == '0) begin
                  res_n   = sred[W-1:0];
                  err_n   = 1'b0;
                  ov_n    = 1'b1;
`ifdef FRACMOD_CHECK_VERIFY_EN
                  match_n = (sred[W-1:0] == exp_r);
`endif
                  state_n = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               ov_n    = 1'b0;
               state_n = IDLE;
            end
         end
         default: begin
            ov_n    = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         m_r       <= '0;
         acc       <= '0;
         cnt       <= '0;
         res       <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         bad       <= 1'b0;
`ifdef FRACMOD_CHECK_VERIFY_EN
         exp_r     <= '0;
         match     <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         a_r       <= a_n;
         b_r       <= b_n;
         m_r       <= m_n;
         acc       <= acc_n;
         cnt       <= cnt_n;
         res       <= res_n;
         err       <= err_n;
         out_valid <= ov_n;
         bad       <= bad_n;
`ifdef FRACMOD_CHECK_VERIFY_EN
         exp_r     <= exp_n;
         match     <= match_n;
`endif
      end
   end

endmodule

// File: tb/tb_fracmod_check_mul.sv
// tb/tb_fracmod_check_mul.sv - directed and random checks of fracmod_check_mul against (a*b)%modu
// Verify-output checks compiled in when FRACMOD_CHECK_VERIFY_EN is defined.
module tb_fracmod_check_mul;

   localparam int W = 13;
   localparam int Q = 5167;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0, b = '0, modu = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] res;
   logic         err;
`ifdef FRACMOD_CHECK_VERIFY_EN
   logic [W-1:0] exp_in = '0;
   logic         match;
`endif

   int nchk = 0;
   int nfail = 0;

   fracmod_check_mul #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .modu(modu),
`ifdef FRACMOD_CHECK_VERIFY_EN
      .exp(exp_in), .match(match),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .res(res), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nchk++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Runs one operation; hold cycles of back-pressure in DONE before out_ready.
   task automatic do_op(input int av, input int bv, input int mv, input int ev, input int hold);
      bit     bad;
      longint er;
      int     lat, k;
      bad = (av >= mv) || (bv >= mv) || (mv < 2);
      er  = bad ? 0 : (longint'(av) * longint'(bv)) % longint'(mv);
      lat = bad ? 1 : W;
      chk("in_ready_idle", 32'(in_ready), 1);
      a = W'(av); b = W'(bv); modu = W'(mv); in_valid = 1'b1;
`ifdef FRACMOD_CHECK_VERIFY_EN
      exp_in = W'(ev);
`endif
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); modu = W'($urandom);
`ifdef FRACMOD_CHECK_VERIFY_EN
      exp_in = W'($urandom);
`endif
      chk("in_ready_busy", 32'(in_ready), 0);
      k = 0;
      while (!out_valid && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk("latency", k, lat);
      chk("res", 32'(res), 32'(er));
      chk("err", 32'(err), 32'(bad));
`ifdef FRACMOD_CHECK_VERIFY_EN
      chk("match", 32'(match), 32'(!bad && (er == longint'(ev))));
`endif
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_res", 32'(res), 32'(er));
         chk("hold_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_valid", 32'(out_valid), 0);
      chk("release_in_ready", 32'(in_ready), 1);
      chk("release_res_kept", 32'(res), 32'(er));
   endtask

   initial begin
      int  mv, av, bv;
      bit  seen;
      #12;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_res", 32'(res), 0);
      chk("rst_err", 32'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      do_op(2, 3, Q, 6, 0);
      do_op(Q - 1, Q - 1, Q, 1, 0);
      do_op(0, 4000, Q, 0, 0);
      do_op(Q, 1, Q, 0, 0);
      do_op(5, 3, 1, 0, 0);
      do_op(1, 7, 8191, 7, 0);
      do_op(1234, 4321, Q, 0, 5);

      // Reset in the middle of MUL aborts without a result.
      a = W'(100); b = W'(200); modu = W'(Q); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(in_ready), 1);
      chk("abort_res_cleared", 32'(res), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_valid", 32'(seen), 0);
      do_op(7, 9, Q, 63, 0);

`ifdef FRACMOD_CHECK_VERIFY_EN
      do_op(2584, 2, Q, 1, 0);
      do_op(2584, 2, Q, 2, 0);
`endif

      // Random legal operands, plus out-of-range ones.
      for (int i = 0; i < 16; i++) begin
         mv = (i < 6) ? Q : int'($urandom_range(8191, 2));
         av = int'($urandom_range(mv - 1, 0));
         bv = int'($urandom_range(mv - 1, 0));
         do_op(av, bv, mv, int'((longint'(av) * bv) % mv), int'($urandom_range(2, 0)));
      end
      for (int i = 0; i < 4; i++) begin
         mv = int'($urandom_range(8191, 2));
         av = (i % 2 == 0) ? int'($urandom_range(8191, mv)) : int'($urandom_range(mv - 1, 0));
         bv = (i % 2 == 1) ? int'($urandom_range(8191, mv)) : int'($urandom_range(mv - 1, 0));
         do_op(av, bv, mv, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
